// File: rtl/board_state_ctrl.sv
// board_state_ctrl: game-state stage upstream of the board renderer.
// Holds the 8x8 board with a registered read port, moves the select box,
// runs the pick/place move sequence, tracks the side to move, detects a
// king capture and issues one-cycle redraw requests.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   btn_up/dn/lt/rt     one-cycle cursor pulses (up/lt decrement y/x)
//   btn_sel             one-cycle pick/place pulse
//   view_x, view_y      renderer read address (column, row)
//   piece_read          registered piece code at (view_x, view_y)
//   box_x, box_y        select box position
//   src_valid, src_x/y  picked source square
//   current_player      1 = white to move, 0 = black to move
//   winning_msg         game over, current_player is the winner
//   render_busy         renderer is drawing
//   render_start        one-cycle redraw request
module board_state_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_lt,
    input  logic       btn_rt,
    input  logic       btn_sel,
    input  logic [2:0] view_x,
    input  logic [2:0] view_y,
    output logic [3:0] piece_read,
    output logic [2:0] box_x,
    output logic [2:0] box_y,
    output logic       src_valid,
    output logic [2:0] src_x,
    output logic [2:0] src_y,
    output logic       current_player,
    output logic       winning_msg,
    input  logic       render_busy,
    output logic       render_start
);

    localparam int unsigned COORD_W = 3;
    localparam int unsigned PIECE_W = 4;
    localparam int unsigned SQ_W    = 6;
    localparam int unsigned NUM_SQ  = 64;

    localparam logic [PIECE_W-1:0] BLACK_KING = PIECE_W'(6);
    localparam logic [PIECE_W-1:0] WHITE_KING = PIECE_W'(12);

    typedef enum logic [2:0] {
        S_PICK,
        S_PLACE,
        S_WRITE_DST,
        S_CLEAR_SRC,
        S_WIN
    } state_t;

    // Initial layout for square index {row, col}.
    function automatic logic [PIECE_W-1:0] init_piece(input logic [SQ_W-1:0] idx);
        logic [PIECE_W-1:0] back;
        case (idx[2:0])
            3'd0, 3'd7: back = PIECE_W'(4);
            3'd1, 3'd6: back = PIECE_W'(2);
            3'd2, 3'd5: back = PIECE_W'(3);
            3'd3:       back = PIECE_W'(5);
            default:    back = PIECE_W'(6);
        endcase
        case (idx[5:3])
            3'd0:    init_piece = back;
            3'd1:    init_piece = PIECE_W'(1);
            3'd6:    init_piece = PIECE_W'(7);
            3'd7:    init_piece = back + PIECE_W'(6);
            default: init_piece = '0;
        endcase
    endfunction

    logic [PIECE_W-1:0] board [NUM_SQ];

    state_t             state, state_next;
    logic [COORD_W-1:0] box_x_next, box_y_next;
    logic [COORD_W-1:0] src_x_next, src_y_next;
    logic [COORD_W-1:0] dst_x, dst_y, dst_x_next, dst_y_next;
    logic               src_valid_next;
    logic               current_player_next;
    logic               winning_msg_next;
    logic [PIECE_W-1:0] captured, captured_next;
    logic               pending, pending_next;
    logic               render_start_next;
    logic               redraw_event;

    logic               wr_en;
    logic [SQ_W-1:0]    wr_addr;
    logic [PIECE_W-1:0] wr_data;

    logic [PIECE_W-1:0] box_piece;
    logic [PIECE_W-1:0] src_piece;
    logic               box_owned;
    logic [2:0]         dir_count;
    logic               cursor_ok;

    assign box_piece = board[{box_y, box_x}];
    assign src_piece = board[{src_y, src_x}];
    assign box_owned = current_player ? (box_piece >= PIECE_W'(7) && box_piece <= PIECE_W'(12))
                                      : (box_piece >= PIECE_W'(1) && box_piece <= PIECE_W'(6));
    assign dir_count = 3'(btn_up) + 3'(btn_dn) + 3'(btn_lt) + 3'(btn_rt);
    assign cursor_ok = (state == S_PICK || state == S_PLACE) && (dir_count == 3'd1);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_PICK;
            box_x          <= '0;
            box_y          <= '0;
            src_x          <= '0;
            src_y          <= '0;
            dst_x          <= '0;
            dst_y          <= '0;
            src_valid      <= 1'b0;
            current_player <= 1'b1;
            winning_msg    <= 1'b0;
            captured       <= '0;
            pending        <= 1'b1;
            render_start   <= 1'b0;
            piece_read     <= '0;
            for (int i = 0; i < NUM_SQ; i++) begin
                board[i] <= init_piece(SQ_W'(i));
            end
        end else begin
            state          <= state_next;
            box_x          <= box_x_next;
            box_y          <= box_y_next;
            src_x          <= src_x_next;
            src_y          <= src_y_next;
            dst_x          <= dst_x_next;
            dst_y          <= dst_y_next;
            src_valid      <= src_valid_next;
            current_player <= current_player_next;
            winning_msg    <= winning_msg_next;
            captured       <= captured_next;
            pending        <= pending_next;
            render_start   <= render_start_next;
            // Read samples the pre-write contents, so a same-cycle write returns old data.
            piece_read     <= board[{view_y, view_x}];
            if (wr_en) begin
                board[wr_addr] <= wr_data;
            end
        end
    end

    // Next-state, cursor, move sequencing and redraw handshake.
    always_comb begin
        state_next          = state;
        box_x_next          = box_x;
        box_y_next          = box_y;
        src_x_next          = src_x;
        src_y_next          = src_y;
        dst_x_next          = dst_x;
        dst_y_next          = dst_y;
        src_valid_next      = src_valid;
        current_player_next = current_player;
        winning_msg_next    = winning_msg;
        captured_next       = captured;
        redraw_event        = 1'b0;
        wr_en               = 1'b0;
        wr_addr             = '0;
        wr_data             = '0;

        // Single-direction cursor move with saturation at the board edges.
        if (cursor_ok) begin
            if (btn_up && box_y != '0) begin
                box_y_next   = box_y - COORD_W'(1);
                redraw_event = 1'b1;
            end
            if (btn_dn && box_y != '1) begin
                box_y_next   = box_y + COORD_W'(1);
                redraw_event = 1'b1;
            end
            if (btn_lt && box_x != '0) begin
                box_x_next   = box_x - COORD_W'(1);
                redraw_event = 1'b1;
            end
            if (btn_rt && box_x != '1) begin
                box_x_next   = box_x + COORD_W'(1);
                redraw_event = 1'b1;
            end
        end

        case (state)
            S_PICK: begin
                if (btn_sel && box_owned) begin
                    src_x_next     = box_x;
                    src_y_next     = box_y;
                    src_valid_next = 1'b1;
                    redraw_event   = 1'b1;
                    state_next     = S_PLACE;
                end
            end
            S_PLACE: begin
                if (btn_sel) begin
                    if (box_x == src_x && box_y == src_y) begin
                        src_valid_next = 1'b0;
                        redraw_event   = 1'b1;
                        state_next     = S_PICK;
                    end else if (box_owned) begin
                        src_x_next   = box_x;
                        src_y_next   = box_y;
                        redraw_event = 1'b1;
                    end else begin
                        dst_x_next    = box_x;
                        dst_y_next    = box_y;
                        captured_next = box_piece;
                        state_next    = S_WRITE_DST;
                    end
                end
            end
            S_WRITE_DST: begin
                wr_en      = 1'b1;
                wr_addr    = {dst_y, dst_x};
                wr_data    = src_piece;
                state_next = S_CLEAR_SRC;
            end
            S_CLEAR_SRC: begin
                wr_en          = 1'b1;
                wr_addr        = {src_y, src_x};
                wr_data        = '0;
                src_valid_next = 1'b0;
                redraw_event   = 1'b1;
                if (captured == BLACK_KING || captured == WHITE_KING) begin
                    winning_msg_next = 1'b1;
                    state_next       = S_WIN;
                end else begin
                    current_player_next = ~current_player;
                    state_next          = S_PICK;
                end
            end
            S_WIN: begin
                state_next = S_WIN;
            end
            default: begin
                state_next = S_PICK;
            end
        endcase

        // A request goes out when the renderer is idle; a same-cycle event re-arms it.
        render_start_next = pending & ~render_busy;
        pending_next      = redraw_event | (pending & render_busy);
    end

endmodule

// File: tb/tb_board_state_ctrl.sv
// Randomized scoreboard bench for board_state_ctrl with a move-level reference model.
module tb_board_state_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_dn = 1'b0, btn_lt = 1'b0, btn_rt = 1'b0, btn_sel = 1'b0;
    logic [2:0] view_x = '0, view_y = '0;
    logic [3:0] piece_read;
    logic [2:0] box_x, box_y, src_x, src_y;
    logic       src_valid, current_player, winning_msg;
    logic       render_busy = 1'b0;
    logic       render_start;

    board_state_ctrl dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_dn(btn_dn), .btn_lt(btn_lt), .btn_rt(btn_rt),
        .btn_sel(btn_sel), .view_x(view_x), .view_y(view_y),
        .piece_read(piece_read), .box_x(box_x), .box_y(box_y),
        .src_valid(src_valid), .src_x(src_x), .src_y(src_y),
        .current_player(current_player), .winning_msg(winning_msg),
        .render_busy(render_busy), .render_start(render_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk_regs;
        bit chk_piece;
        int piece;
        int bx, by, sx, sy;
        bit sv, pl, win, rs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   rs_seen = 0;

    // Reference model: game-level state, moves applied atomically.
    int mb[64];
    int mbx, mby, msx, msy;
    bit mpicked, mplayer, mwon, mpend;
    int mdelay;

    function automatic bit owned(int p, bit pl);
        return pl ? (p >= 7 && p <= 12) : (p >= 1 && p <= 6);
    endfunction

    task automatic model_reset();
        int back[8];
        back = '{4, 2, 3, 5, 6, 3, 2, 4};
        for (int i = 0; i < 64; i++) mb[i] = 0;
        for (int x = 0; x < 8; x++) begin
            mb[x]      = back[x];
            mb[8 + x]  = 1;
            mb[48 + x] = 7;
            mb[56 + x] = back[x] + 6;
        end
        mbx = 0; mby = 0; msx = 0; msy = 0;
        mpicked = 0; mplayer = 1; mwon = 0; mpend = 1; mdelay = 0;
    endtask

    // One clock of stimulus; the expected post-edge response is queued.
    task automatic cyc(bit u, bit d, bit l, bit r, bit s, int vx, int vy, bit busy, bit rst);
        exp_t e;
        bit   ev, clear, active;
        int   nx, ny, cap;
        @(negedge clk);
        btn_up = u; btn_dn = d; btn_lt = l; btn_rt = r; btn_sel = s;
        view_x = 3'(vx); view_y = 3'(vy); render_busy = busy; reset = rst;
        if (rst) begin
            model_reset();
            e.piece = 0; e.rs = 0; e.chk_regs = 1; e.chk_piece = 1;
        end else begin
            e.piece = mb[vy * 8 + vx];
            e.rs    = mpend && !busy;
            ev = 0; clear = 0;
            active = (mdelay == 0) && !mwon;
            if (mdelay == 1) begin ev = 1; clear = 1; end
            if (mdelay > 0) mdelay--;
            if (active) begin
                if (s) begin
                    if (!mpicked) begin
                        if (owned(mb[mby * 8 + mbx], mplayer)) begin
                            mpicked = 1; msx = mbx; msy = mby; ev = 1;
                        end
                    end else if (mbx == msx && mby == msy) begin
                        mpicked = 0; ev = 1;
                    end else if (owned(mb[mby * 8 + mbx], mplayer)) begin
                        msx = mbx; msy = mby; ev = 1;
                    end else begin
                        cap = mb[mby * 8 + mbx];
                        mb[mby * 8 + mbx] = mb[msy * 8 + msx];
                        mb[msy * 8 + msx] = 0;
                        mpicked = 0;
                        if (cap == 6 || cap == 12) mwon = 1;
                        else mplayer = !mplayer;
                        mdelay = 2;
                    end
                end
                if (int'(u) + int'(d) + int'(l) + int'(r) == 1) begin
                    nx = mbx; ny = mby;
                    if (u && ny > 0) ny--;
                    if (d && ny < 7) ny++;
                    if (l && nx > 0) nx--;
                    if (r && nx < 7) nx++;
                    if (nx != mbx || ny != mby) ev = 1;
                    mbx = nx; mby = ny;
                end
            end
            mpend = ev || (mpend && busy);
            e.chk_regs  = (mdelay == 0);
            e.chk_piece = e.chk_regs && !clear;
        end
        e.bx = mbx; e.by = mby; e.sx = msx; e.sy = msy;
        e.sv = mpicked; e.pl = mplayer; e.win = mwon;
        q.push_back(e);
    endtask

    task automatic press(bit u, bit d, bit l, bit r, bit s);
        cyc(u, d, l, r, s, int'($urandom_range(7)), int'($urandom_range(7)), 1'b0, 1'b0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) press(0, 0, 0, 0, 0);
    endtask

    task automatic goto(int tx, int ty);
        for (int i = 0; i < 20 && (mbx != tx || mby != ty); i++) begin
            if (mbx < tx)      press(0, 0, 0, 1, 0);
            else if (mbx > tx) press(0, 0, 1, 0, 0);
            else if (mby < ty) press(0, 1, 0, 0, 0);
            else               press(1, 0, 0, 0, 0);
        end
    endtask

    task automatic move(int fx, int fy, int tx, int ty);
        goto(fx, fy); press(0, 0, 0, 0, 1);
        goto(tx, ty); press(0, 0, 0, 0, 1);
        idle(3);
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per clock and compares the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (render_start === 1'b1) rs_seen++;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_piece) chk("piece_read", int'(piece_read), e.piece);
                if (e.chk_regs) begin
                    chk("box_x", int'(box_x), e.bx);
                    chk("box_y", int'(box_y), e.by);
                    chk("src_valid", int'(src_valid), int'(e.sv));
                    chk("src_x", int'(src_x), e.sx);
                    chk("src_y", int'(src_y), e.sy);
                    chk("current_player", int'(current_player), int'(e.pl));
                    chk("winning_msg", int'(winning_msg), int'(e.win));
                end
                chk("render_start", int'(render_start), int'(e.rs));
            end
        end
    end

    initial begin
        int rs_before;
        bit busy;
        model_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Full board readback, including the initial redraw request.
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                cyc(0, 0, 0, 0, 0, x, y, 0, 0);
        cyc(0, 0, 0, 0, 0, 4, 7, 0, 0);
        cyc(0, 0, 0, 0, 0, 3, 0, 0, 0);

        // Cursor saturation and multi-direction rejection.
        press(0, 0, 1, 0, 0);
        press(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) press(0, 0, 0, 1, 0);
        press(0, 1, 0, 0, 0);
        press(1, 0, 0, 1, 0);
        press(1, 1, 1, 1, 0);

        // White selects a black pawn, then picks and cancels the knight.
        goto(0, 1); press(0, 0, 0, 0, 1); idle(2);
        goto(1, 7); press(0, 0, 0, 0, 1); idle(1); press(0, 0, 0, 0, 1); idle(2);

        // Pick, re-pick, place.
        goto(3, 6); press(0, 0, 0, 0, 1);
        move(4, 6, 4, 4);
        cyc(0, 0, 0, 0, 0, 4, 4, 0, 0);
        cyc(0, 0, 0, 0, 0, 4, 6, 0, 0);

        // Sel together with a direction pulse uses the old box position.
        goto(4, 1); press(0, 1, 0, 0, 1); idle(1);
        goto(4, 3); press(0, 0, 0, 0, 1); idle(3);

        // Queen next to the black king, then the capture.
        move(3, 7, 4, 1);
        move(0, 1, 0, 2);
        move(4, 1, 4, 0);
        for (int i = 0; i < 20; i++)
            press(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));

        // Redraw coalescing while the renderer is busy.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rs_before = rs_seen;
        cyc(0, 0, 0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("coalesced_render_starts", rs_seen - rs_before, 1);

        // Randomized play with busy bursts and occasional resets.
        busy = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(9) == 0) busy = !busy;
            cyc($urandom_range(5) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
                $urandom_range(5) == 0, $urandom_range(4) == 0,
                int'($urandom_range(7)), int'($urandom_range(7)), busy,
                ($urandom_range(599) == 0) || (mwon && $urandom_range(39) == 0));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
